// File: rtl/serial_adder_ctrl_if.sv
// Request/result channel between a requester and the bit-serial adder controller.
// Handshake: start is sampled on a rising edge only while busy is low. That edge
// accepts a, b and cin. done then pulses for one cycle, with sum/cout valid from
// that cycle until the next completion.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       fsm_state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, fsm_state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, fsm_state
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell is stepped over WIDTH cycles, LSB first,
// under a start/done handshake. The result registers hold until the next completion.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] p_sh;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    // Written as shift/or so that it also holds when WIDTH is 1.
    assign p_next = (p_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            p_sh   <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        c_q   <= bus.cin;
                        p_sh  <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    p_sh <= p_next;
                    c_q  <= fa_cout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum_q  <= p_next;
                        cout_q <= fa_cout;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status is a pure decode of the state register: no input reaches busy/done.
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.fsm_state = state;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences one `full_adder` instance over WIDTH cycles. It adds two WIDTH-bit operands plus carry-in, processing one bit per cycle, LSB first. It sits between a requester using a start/done handshake and the single-bit adder datapath. The block trades latency for area against a ripple-carry array of `full_adder` cells.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry

One clock; reset is synchronous and active-high.

## Operation
- Internal state:
  - operand shift registers `a_sh` and `b_sh` (WIDTH each)
  - carry flop `c_q`
  - partial-sum shift register `p_sh` (WIDTH)
  - bit counter `cnt` of width clog2(WIDTH+1)
  - result registers driving `sum` and `cout`
- The single `full_adder` instance is wired as a = `a_sh[0]`, b = `b_sh[0]`, cin = `c_q`. Its sum output feeds `p_sh` and its cout output feeds `c_q`.
- FSM states are IDLE, RUN and DONE.
  - IDLE: if start=1, load `a_sh`=a, `b_sh`=b, `c_q`=cin, `p_sh`=0, `cnt`=0, then go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle, shift `a_sh` and `b_sh` right by one. Shift the adder sum bit into the MSB of `p_sh` while shifting `p_sh` right. Set `c_q` = adder cout and increment `cnt`.
  - RUN exit: when `cnt` == WIDTH-1 (the last bit this cycle), go to DONE. On that same edge, write `sum` = {adder sum, `p_sh`[WIDTH-1:1]} and `cout` = adder cout.
  - DONE: assert done for one cycle, then unconditionally go to IDLE.
- busy = (state != IDLE), decoded from state registers with no combinational path from inputs.
- start is ignored in RUN and DONE; no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- a, b and cin may change freely after acceptance without affecting the operation in flight.
- sum and cout hold their last result until the next completion. They do not change during a subsequent RUN.
- Arithmetic: {cout, sum} = a + b + cin, taken modulo 2^(WIDTH+1), with no signed interpretation.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0
  - `cnt` = 0, `c_q` = 0
- Latency: start accepted at edge k gives busy=1 after edge k, result written at edge k+WIDTH, and done=1 in the cycle after edge k+WIDTH.
  - Back to IDLE at edge k+WIDTH+1.
  - Next start can be accepted at edge k+WIDTH+2.
  - Throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: RUN lasts exactly one cycle; done follows at edge k+1.
- Reset asserted mid-RUN or in DONE: on the next edge, return to IDLE and clear every output to its reset value. The operation in flight is discarded and no done pulse is issued.
- rst and start high on the same edge: reset wins and start is not accepted.
- done is never high for more than one consecutive cycle. done=1 implies busy=1 in the same cycle.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0: done exactly 9 cycles after the accepting edge, with sum=0x96 and cout=0. busy is high for cycles 1..9.
- WIDTH=8, a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 gives sum=0xFF, cout=1. The two runs are issued back to back, with the second start held high so it is accepted in the first IDLE cycle.
- Operand change and start while busy: after acceptance, drive a=0x00, b=0x00 and pulse start during RUN. The result must reflect the captured operands, and no second operation may start.
- Reset mid-operation: assert rst at cycle 4 of RUN. Next cycle shows busy=0, done=0, sum=0, cout=0, and no done pulse follows. A new start then completes correctly.
- WIDTH=1 instance: exhaustively drive all 8 combinations of a, b and cin. Each gives {cout, sum} = a+b+cin, with done 2 cycles after acceptance.
- Randomized WIDTH=16: at least 1000 operations against a golden a+b+cin model. Check the done-pulse width, that sum/cout are stable between completions, and the WIDTH+2 throughput.
